// File: rtl/adsr_vca_pkg.sv
// Shared defaults for the ADSR envelope path (adsr and adsr_vca).
package adsr_vca_pkg;
  localparam int DEF_WIDTH        = 8;
  localparam int DEF_SAMPLE_WIDTH = 12;
  localparam int DEF_SLEW_STEP    = 4;

  function automatic int env_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/adsr_vca_env_slew.sv
// Slew limiter: moves env_eff toward tgt by at most SLEW_STEP per tick, never overshooting.
module env_slew
  import adsr_vca_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SLEW_STEP = DEF_SLEW_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] env_eff
);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(SLEW_STEP);

  logic [WIDTH-1:0] r_env;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_next;

  // env+STEP / env-STEP are only taken when the gap exceeds STEP, so neither can wrap
  always_comb begin
    w_diff = '0;
    w_next = r_env;
    if (tgt >= r_env) begin
      w_diff = tgt - r_env;
      w_next = (w_diff <= STEP) ? tgt : r_env + STEP;
    end else begin
      w_diff = r_env - tgt;
      w_next = (w_diff <= STEP) ? tgt : r_env - STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_env <= '0;
    else if (tick) r_env <= w_next;
  end

  assign env_eff = r_env;
endmodule

// File: rtl/adsr_vca.sv
// Envelope VCA: syncs the sample-rate tick, slews the envelope, multiplies and rounds the sample.
module adsr_vca
  import adsr_vca_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           low_clk,
  input  logic [WIDTH-1:0]               env_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           mute,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           sample_valid,
  output logic [WIDTH-1:0]               env_eff
);
  localparam int               PW      = SAMPLE_WIDTH + WIDTH + 1;
  localparam logic [WIDTH-1:0] ENV_MAX = WIDTH'(env_max(WIDTH));
  localparam int               STAGES  = 3;

  logic                           r_lclk_s1, r_lclk_s2, r_lclk_d;
  logic                           w_tick;
  logic [WIDTH-1:0]               w_tgt;
  logic [STAGES-1:0]              r_vld_pipe;
  logic signed [SAMPLE_WIDTH-1:0] r_x, r_x2;
  logic signed [PW-1:0]           r_prod;
  logic [WIDTH-1:0]               r_env_s2;
  logic signed [PW-1:0]           w_prod, w_sum, w_shift;
  logic                           w_in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lclk_s1 <= 1'b0;
      r_lclk_s2 <= 1'b0;
      r_lclk_d  <= 1'b0;
    end else begin
      r_lclk_s1 <= low_clk;
      r_lclk_s2 <= r_lclk_s1;
      r_lclk_d  <= r_lclk_s2;
    end
  end

  assign w_tick = r_lclk_s2 & ~r_lclk_d;
  assign w_tgt  = mute ? '0 : env_in;

  env_slew #(.WIDTH(WIDTH), .SLEW_STEP(SLEW_STEP)) u_slew (
    .clk     (clk),
    .reset   (reset),
    .tick    (w_tick),
    .tgt     (w_tgt),
    .env_eff (env_eff)
  );

  // env_eff is zero-extended so the full unsigned range acts as a positive gain
  assign w_prod  = PW'(r_x) * PW'($signed({1'b0, env_eff}));
  assign w_sum   = r_prod + PW'(1 << (WIDTH - 1));
  assign w_shift = w_sum >>> WIDTH;
  assign w_in_range = (w_shift[PW-1:SAMPLE_WIDTH-1] == '0) || (&w_shift[PW-1:SAMPLE_WIDTH-1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_x        <= '0;
      r_x2       <= '0;
      r_prod     <= '0;
      r_env_s2   <= '0;
      sample_out <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-2:0], w_tick};
      if (w_tick) r_x <= sample_in;
      if (r_vld_pipe[0]) begin
        r_prod   <= w_prod;
        r_x2     <= r_x;
        r_env_s2 <= env_eff;
      end
      if (r_vld_pipe[1])
        sample_out <= (r_env_s2 == ENV_MAX) ? r_x2 : w_shift[SAMPLE_WIDTH-1:0];
    end
  end

  assign sample_valid = r_vld_pipe[STAGES-1];

  // Gain never exceeds unity, so the rounded product must fit the sample width
  always @(posedge clk) begin
    if (reset && r_vld_pipe[1] && r_env_s2 != ENV_MAX)
      assert (w_in_range);
  end
endmodule

// File: tb/tb_adsr_vca.sv
// Bench for adsr_vca: table vectors plus ramp sequences, checked through a scoreboard queue.
module tb_adsr_vca;
  logic                clk = 1'b0;
  logic                reset;
  logic                low_clk;
  logic [7:0]          env_in;
  logic signed [11:0]  sample_in;
  logic                mute;
  logic signed [11:0]  sample_out;
  logic                sample_valid;
  logic [7:0]          env_eff;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic signed [11:0] out;
    logic [7:0]         env;
    int                 cyc;
  } exp_t;

  typedef struct {
    logic [7:0]         e;
    logic signed [11:0] x;
    logic               m;
    logic [7:0]         xe;
    logic signed [11:0] xo;
  } vec_t;

  exp_t       sb[$];
  vec_t       tab[$];
  logic [7:0] m_env = 8'd0;

  adsr_vca dut (
    .clk          (clk),
    .reset        (reset),
    .low_clk      (low_clk),
    .env_in       (env_in),
    .sample_in    (sample_in),
    .mute         (mute),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .env_eff      (env_eff)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] slew(input logic [7:0] e, input logic [7:0] t);
    if (t >= e) return (t - e <= 8'd4) ? t : e + 8'd4;
    else        return (e - t <= 8'd4) ? t : e - 8'd4;
  endfunction

  function automatic logic signed [11:0] gain(input logic signed [11:0] x, input logic [7:0] e);
    int p;
    if (e == 8'd255) return x;
    p = int'(x) * int'({24'd0, e}) + 128;
    return 12'(p >>> 8);
  endfunction

  always @(negedge clk) begin
    if (reset && sample_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got pulse expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sample_out", int'(sample_out), int'(e.out));
        chk("env_eff", int'(env_eff), int'(e.env));
        chk("valid_latency", cyc - e.cyc, 5);
      end
    end
  end

  // One low_clk period; inputs are scrambled after capture to prove they are ignored between ticks
  task automatic tick(input logic [7:0] e, input logic signed [11:0] x, input logic m,
                      input logic [7:0] xe, input logic signed [11:0] xo);
    exp_t t;
    @(posedge clk); #1;
    env_in = e; sample_in = x; mute = m; low_clk = 1'b1;
    t.out = xo; t.env = xe; t.cyc = cyc;
    sb.push_back(t);
    repeat (3) @(posedge clk); #1;
    env_in = 8'($urandom); sample_in = 12'($urandom); mute = 1'($urandom);
    @(posedge clk); #1 low_clk = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic mtick(input logic [7:0] e, input logic signed [11:0] x, input logic m);
    logic [7:0] ne;
    ne = slew(m_env, m ? 8'd0 : e);
    tick(e, x, m, ne, gain(x, ne));
    m_env = ne;
  endtask

  task automatic run_tab(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tick(tab[i].e, tab[i].x, tab[i].m, tab[i].xe, tab[i].xo);
      m_env = tab[i].xe;
    end
  endtask

  task automatic ramp_to(input logic [7:0] e);
    for (int k = 0; k < 80 && m_env != e; k++) mtick(e, 12'($urandom), 1'b0);
  endtask

  initial begin
    tab.push_back('{8'd10,  12'sd100,   1'b0, 8'd4,   12'sd2});
    tab.push_back('{8'd10,  12'sd100,   1'b0, 8'd8,   12'sd3});
    tab.push_back('{8'd10,  12'sd100,   1'b0, 8'd10,  12'sd4});
    tab.push_back('{8'd10,  -12'sd100,  1'b0, 8'd10,  -12'sd4});
    tab.push_back('{8'd128, 12'sd3,     1'b0, 8'd128, 12'sd2});
    tab.push_back('{8'd128, -12'sd3,    1'b0, 8'd128, -12'sd1});
    tab.push_back('{8'd128, 12'sd2047,  1'b0, 8'd128, 12'sd1024});
    tab.push_back('{8'd128, -12'sd2048, 1'b0, 8'd128, -12'sd1024});
    tab.push_back('{8'd254, -12'sd2048, 1'b0, 8'd254, -12'sd2032});
    tab.push_back('{8'd254, 12'sd2047,  1'b0, 8'd254, 12'sd2031});
    tab.push_back('{8'd255, 12'sd1000,  1'b0, 8'd255, 12'sd1000});
    tab.push_back('{8'd255, -12'sd2048, 1'b0, 8'd255, -12'sd2048});
    tab.push_back('{8'd255, 12'sd2047,  1'b0, 8'd255, 12'sd2047});
    tab.push_back('{8'd200, 12'sd2047,  1'b1, 8'd0,   12'sd0});
    tab.push_back('{8'd255, -12'sd2048, 1'b1, 8'd0,   12'sd0});

    reset = 1'b0; low_clk = 1'b0; env_in = 8'd0; sample_in = 12'sd0; mute = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_sample_out", int'(sample_out), 0);
    chk("reset_valid", int'(sample_valid), 0);
    chk("reset_env_eff", int'(env_eff), 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);

    run_tab(0, 3);          // slew 4,8,10,10 with no overshoot
    ramp_to(8'd128);
    run_tab(4, 7);          // round half up at env 128
    ramp_to(8'd254);
    run_tab(8, 9);          // extremes at env 254
    run_tab(10, 12);        // unity bypass
    ramp_to(8'd200);
    for (int k = 0; k < 50; k++) begin
      logic [7:0]         xe;
      logic signed [11:0] x;
      xe = 8'(200 - 4 * (k + 1));
      x  = 12'($urandom);
      tick(8'($urandom), x, 1'b1, xe, gain(x, xe));
      m_env = xe;
    end
    run_tab(13, 14);        // muted output is silent, mute beats env_in

    ramp_to(8'd40);
    for (int k = 0; k < 2; k++) mtick(8'd40, 12'sd300, 1'b0);
    @(posedge clk); #1;
    env_in = 8'd40; sample_in = 12'sd500; mute = 1'b0; low_clk = 1'b1;
    repeat (4) @(posedge clk); #1;   // sample now held in the product stage
    chk("pre_reset_env_eff", int'(env_eff), 40);
    chk("pre_reset_sample_out", int'(sample_out), 47);
    reset = 1'b0; low_clk = 1'b0;
    #1;
    chk("midreset_sample_out", int'(sample_out), 0);
    chk("midreset_valid", int'(sample_valid), 0);
    chk("midreset_env_eff", int'(env_eff), 0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    m_env = 8'd0;
    repeat (12) @(posedge clk);

    for (int k = 0; k < 64; k++) begin
      logic [7:0] xe;
      xe = (k == 63) ? 8'd255 : 8'(4 * (k + 1));
      tick(8'd255, 12'sd1000, 1'b0, xe, (k == 63) ? 12'sd1000 : gain(12'sd1000, xe));
      m_env = xe;
    end

    repeat (10) @(posedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
